// File: rtl/ef_ctrl_pkg.sv
// Shared types and constants for the extremum-finder autorange controller.
package ef_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        MEASURE = 3'd2,
        EVAL    = 3'd3,
        SETTLE  = 3'd4
    } state_t;

    localparam int LOG_COUNT_W = 5;
    localparam int SHIFT_W     = 3;
    localparam logic [SHIFT_W-1:0] SHIFT_MAX = 3'd7;

    // Peak-to-peak of two signed W-bit values needs one extra bit.
    function automatic int amp_width(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/ef_range_eval.sv
// Combinational amplitude path: raw peak-to-peak from the finder results,
// scaling of the registered amplitude and the threshold decisions.
module ef_range_eval
    import ef_ctrl_pkg::*;
#(
    parameter int              W         = 32,
    parameter int              AW        = amp_width(W),
    parameter longint unsigned HI_THRESH = 64'd24576,
    parameter longint unsigned LO_THRESH = 64'd8192
) (
    input  logic signed [W-1:0]       ef_min,
    input  logic signed [W-1:0]       ef_max,
    input  logic        [AW-1:0]      amp_reg,
    input  logic        [SHIFT_W-1:0] shift,
    output logic        [AW-1:0]      amp,
    output logic        [AW-1:0]      scaled,
    output logic                      up,
    output logic                      down,
    output logic                      locked
);

    localparam logic [AW-1:0] HI_V = AW'(HI_THRESH);
    localparam logic [AW-1:0] LO_V = AW'(LO_THRESH);

    logic signed [AW-1:0] diff;

    // Sign-extend before subtracting; a corrupt window (max < min) reads as zero.
    always_comb begin
        diff   = $signed({ef_max[W-1], ef_max}) - $signed({ef_min[W-1], ef_min});
        amp    = diff[AW-1] ? '0 : diff;
        scaled = amp_reg >> shift;
        up     = (scaled > HI_V) && (shift != SHIFT_MAX);
        down   = (scaled < LO_V) && (shift != '0);
        locked = (scaled >= LO_V) && (scaled <= HI_V);
    end

endmodule

// File: rtl/ef_autorange_ctrl.sv
// Autorange controller for the extremum finder: latches window configuration,
// evaluates each window's peak-to-peak and steps the shift in auto mode.
// Optional statistics counters are built when EF_AUTORANGE_STATS_EN is defined.
// Handshake: EF_valid is a one-cycle strobe with no back-pressure; it is only
// acted on in SETTLE or MEASURE and dropped in every other state.
module ef_autorange_ctrl
    import ef_ctrl_pkg::*;
#(
    parameter int              AXIS_TDATA_WIDTH = 32,
    parameter longint unsigned HI_THRESH        = 64'd24576,
    parameter longint unsigned LO_THRESH        = 64'd8192
) (
    input  logic                                SYS_aclk,
    input  logic                                SYS_aresetn,
    input  logic                                CFG_enable,
    input  logic                                CFG_auto,
    input  logic [SHIFT_W-1:0]                  CFG_shift,
    input  logic [LOG_COUNT_W-1:0]              CFG_log_count,
    input  logic [3:0]                          CFG_settle,
    input  logic signed [AXIS_TDATA_WIDTH-1:0]  EF_min,
    input  logic signed [AXIS_TDATA_WIDTH-1:0]  EF_max,
    input  logic                                EF_valid,
    output logic [LOG_COUNT_W-1:0]              EF_log_count,
    output logic [SHIFT_W-1:0]                  EF_shift,
    output logic                                EF_clear,
    output logic [AXIS_TDATA_WIDTH:0]           ST_amplitude,
    output logic                                ST_locked,
    output logic [2:0]                          dbg_state
`ifdef EF_AUTORANGE_STATS_EN
    ,
    output logic [15:0]                         ST_changes,
    output logic [15:0]                         ST_windows
`endif
);

    localparam int AW = amp_width(AXIS_TDATA_WIDTH);

    state_t         state;
    logic [3:0]     settle_cnt;
    logic           auto_q;
    logic [AW-1:0]  amp_q;
    logic [AW-1:0]  amp_now;
    logic [AW-1:0]  scaled;
    logic           up;
    logic           down;
    logic           locked;
    logic           cfg_changed;

    ef_range_eval #(
        .W         (AXIS_TDATA_WIDTH),
        .AW        (AW),
        .HI_THRESH (HI_THRESH),
        .LO_THRESH (LO_THRESH)
    ) u_eval (
        .ef_min  (EF_min),
        .ef_max  (EF_max),
        .amp_reg (amp_q),
        .shift   (EF_shift),
        .amp     (amp_now),
        .scaled  (scaled),
        .up      (up),
        .down    (down),
        .locked  (locked)
    );

    assign dbg_state = state;

    // A configuration change is anything that alters what the finder is told.
    always_comb begin
        cfg_changed = (CFG_log_count != EF_log_count)
                   || (!CFG_auto && (CFG_shift != EF_shift))
                   || (CFG_auto != auto_q);
    end

    // Controller FSM with all outputs registered; disable beats reconfig beats data.
    always_ff @(posedge SYS_aclk) begin
        if (!SYS_aresetn) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            auto_q       <= 1'b0;
            amp_q        <= '0;
            EF_log_count <= '0;
            EF_shift     <= '0;
            EF_clear     <= 1'b0;
            ST_amplitude <= '0;
            ST_locked    <= 1'b0;
`ifdef EF_AUTORANGE_STATS_EN
            ST_changes   <= '0;
            ST_windows   <= '0;
`endif
        end else begin
            EF_clear <= 1'b0;
            if (!CFG_enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        EF_log_count <= CFG_log_count;
                        if (!CFG_auto) EF_shift <= CFG_shift;
                        auto_q <= CFG_auto;
                        state  <= START;
                    end
                    START: begin
                        EF_clear   <= 1'b1;
                        settle_cnt <= CFG_settle;
                        state      <= (CFG_settle != 4'd0) ? SETTLE : MEASURE;
                    end
                    default: begin
                        if (cfg_changed) begin
                            EF_log_count <= CFG_log_count;
                            if (!CFG_auto) EF_shift <= CFG_shift;
                            auto_q <= CFG_auto;
                            state  <= START;
                        end else begin
                            case (state)
                                SETTLE: begin
                                    if (EF_valid) begin
                                        settle_cnt <= settle_cnt - 4'd1;
                                        if (settle_cnt <= 4'd1) state <= MEASURE;
                                    end
                                end
                                MEASURE: begin
                                    if (EF_valid) begin
                                        amp_q <= amp_now;
                                        state <= EVAL;
                                    end
                                end
                                EVAL: begin
                                    ST_amplitude <= scaled;
                                    ST_locked    <= locked;
`ifdef EF_AUTORANGE_STATS_EN
                                    ST_windows   <= ST_windows + 16'd1;
                                    if (auto_q && (up || down) && (ST_changes != 16'hFFFF))
                                        ST_changes <= ST_changes + 16'd1;
`endif
                                    if (auto_q && up) begin
                                        EF_shift <= EF_shift + 3'd1;
                                        state    <= START;
                                    end else if (auto_q && down) begin
                                        EF_shift <= EF_shift - 3'd1;
                                        state    <= START;
                                    end else begin
                                        state <= MEASURE;
                                    end
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ef_autorange_ctrl.sv
// Bench for ef_autorange_ctrl: directed scenarios plus random windows,
// checked against a window-level reference model through an expected queue.
module tb_ef_autorange_ctrl;
    import ef_ctrl_pkg::*;

    localparam int              W  = 32;
    localparam longint unsigned HI = 64'd24576;
    localparam longint unsigned LO = 64'd8192;

    logic               clk = 1'b0;
    logic               aresetn = 1'b0;
    logic               cfg_enable = 1'b0;
    logic               cfg_auto = 1'b0;
    logic [2:0]         cfg_shift = '0;
    logic [4:0]         cfg_log_count = '0;
    logic [3:0]         cfg_settle = '0;
    logic signed [W-1:0] ef_min = '0;
    logic signed [W-1:0] ef_max = '0;
    logic               ef_valid = 1'b0;
    logic [4:0]         ef_log_count;
    logic [2:0]         ef_shift;
    logic               ef_clear;
    logic [W:0]         st_amplitude;
    logic               st_locked;
    logic [2:0]         dbg_state;
`ifdef EF_AUTORANGE_STATS_EN
    logic [15:0]        st_changes;
    logic [15:0]        st_windows;
`endif

    ef_autorange_ctrl #(
        .AXIS_TDATA_WIDTH (W),
        .HI_THRESH        (HI),
        .LO_THRESH        (LO)
    ) dut (
        .SYS_aclk      (clk),
        .SYS_aresetn   (aresetn),
        .CFG_enable    (cfg_enable),
        .CFG_auto      (cfg_auto),
        .CFG_shift     (cfg_shift),
        .CFG_log_count (cfg_log_count),
        .CFG_settle    (cfg_settle),
        .EF_min        (ef_min),
        .EF_max        (ef_max),
        .EF_valid      (ef_valid),
        .EF_log_count  (ef_log_count),
        .EF_shift      (ef_shift),
        .EF_clear      (ef_clear),
        .ST_amplitude  (st_amplitude),
        .ST_locked     (st_locked),
        .dbg_state     (dbg_state)
`ifdef EF_AUTORANGE_STATS_EN
        ,
        .ST_changes    (st_changes),
        .ST_windows    (st_windows)
`endif
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    logic [37:0] exp_q[$];   // {clear, locked, shift[2:0], scaled[32:0]}

    // Reference model (window granularity)
    bit     m_en = 0;
    bit     m_auto = 0;
    int     m_shift = 0;
    int     m_log = 0;
    int     m_settle_rem = 0;
    longint m_amp = 0;
    bit     m_locked = 0;
    int     exp_clears = 0;
    int     clear_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_relatch(input bit au, input int sh, input int lg, input int st);
        m_log = lg;
        if (!au) m_shift = sh;
        m_auto = au;
        m_en = 1;
        m_settle_rem = st;
        exp_clears++;
    endtask

    task automatic model_window(input int mn, input int mx);
        longint a;
        longint sc;
        bit lk;
        bit step;
        logic [32:0] sc_v;
        logic [2:0]  sh_v;
        if (!m_en) return;
        if (m_settle_rem > 0) begin
            m_settle_rem--;
            return;
        end
        a = longint'(mx) - longint'(mn);
        if (a < 0) a = 0;
        sc = a >>> m_shift;
        lk = (sc >= longint'(LO)) && (sc <= longint'(HI));
        step = 0;
        if (m_auto) begin
            if (sc > longint'(HI) && m_shift < 7) begin
                m_shift++;
                step = 1;
            end else if (sc < longint'(LO) && m_shift > 0) begin
                m_shift--;
                step = 1;
            end
        end
        m_amp = sc;
        m_locked = lk;
        if (step) begin
            exp_clears++;
            m_settle_rem = int'(cfg_settle);
        end
        sc_v = sc[32:0];
        sh_v = m_shift[2:0];
        exp_q.push_back({step, lk, sh_v, sc_v});
    endtask

    // Driver tasks
    task automatic apply_cfg(input bit en, input bit au, input int sh, input int lg, input int st);
        @(posedge clk); #1;
        cfg_enable = en; cfg_auto = au; cfg_shift = sh[2:0];
        cfg_log_count = lg[4:0]; cfg_settle = st[3:0];
        if (!en) m_en = 0;
        else if (!m_en) model_relatch(au, sh, lg, st);
        else if (lg != m_log || (!au && sh != m_shift) || au != m_auto) model_relatch(au, sh, lg, st);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic window(input int mn, input int mx);
        @(posedge clk); #1;
        ef_min = mn; ef_max = mx; ef_valid = 1'b1;
        model_window(mn, mx);
        @(posedge clk); #1;
        ef_valid = 1'b0;
        repeat ($urandom_range(5, 8)) @(posedge clk);
        #1;
    endtask

    task automatic window_with_change(input int mn, input int mx, input int lg);
        @(posedge clk); #1;
        ef_min = mn; ef_max = mx; ef_valid = 1'b1; cfg_log_count = lg[4:0];
        model_relatch(cfg_auto, int'(cfg_shift), lg, int'(cfg_settle));
        @(posedge clk); #1;
        ef_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic checkpoint(input string tag);
        state_t es;
        es = !m_en ? IDLE : (m_settle_rem > 0 ? SETTLE : MEASURE);
        check({tag, "_shift"},     ef_shift, m_shift);
        check({tag, "_log_count"}, ef_log_count, m_log);
        check({tag, "_state"},     dbg_state, es);
        check({tag, "_clears"},    clear_cnt, exp_clears);
        check({tag, "_amplitude"}, st_amplitude, m_amp);
        check({tag, "_locked"},    st_locked, m_locked);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        aresetn = 1'b0; cfg_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_en = 0; m_auto = 0; m_shift = 0; m_log = 0; m_settle_rem = 0;
        m_amp = 0; m_locked = 0;
        check({tag, "_rst_shift"},     ef_shift, 0);
        check({tag, "_rst_log_count"}, ef_log_count, 0);
        check({tag, "_rst_clear"},     ef_clear, 0);
        check({tag, "_rst_amplitude"}, st_amplitude, 0);
        check({tag, "_rst_locked"},    st_locked, 0);
        check({tag, "_rst_state"},     dbg_state, IDLE);
        aresetn = 1'b1;
    endtask

    // Monitor: pops an expectation the cycle after each EVAL, then checks the clear pulse
    logic [2:0]  prev_state = 3'd0;
    bit          pend = 0;
    bit          pend_clr = 0;
    logic [37:0] e;
    always @(negedge clk) begin
        if (ef_clear === 1'b1) clear_cnt++;
        if (pend) begin
            check("clear_after_eval", ef_clear, pend_clr);
            pend = 0;
        end
        if (prev_state == EVAL && aresetn) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_eval: got a window result, expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("eval_amplitude", st_amplitude, e[32:0]);
                check("eval_locked",    st_locked, e[36]);
                check("eval_shift",     ef_shift, e[35:33]);
                pend = 1;
                pend_clr = e[37];
            end
        end
        prev_state = dbg_state;
    end

    // Stimulus
    initial begin
        int mn;
        int mx;
        bit au;
        do_reset("init");

        // Manual start
        apply_cfg(1, 0, 2, 3, 0);
        checkpoint("s1");

        // Auto from shift 0 with one settling window
        apply_cfg(1, 0, 0, 3, 1);
        apply_cfg(1, 1, 0, 3, 1);
        repeat (4) window(-20000, 20000);
        checkpoint("s2");

        // Small signal walks shift down to 0 and holds
        apply_cfg(1, 0, 3, 3, 0);
        apply_cfg(1, 1, 3, 3, 0);
        repeat (5) window(-10, 60);
        checkpoint("s3");

        // Saturation at shift 7 with full-scale amplitude
        apply_cfg(1, 0, 7, 3, 0);
        apply_cfg(1, 1, 7, 3, 0);
        repeat (2) window(int'(32'h8000_0000), int'(32'h7fff_ffff));
        checkpoint("s4");

        // Reconfigure in the same cycle as a result
        window_with_change(-100, 100, 5);
        checkpoint("s5");

        // Disable mid-settle, re-enable, then reset mid-measure
        apply_cfg(1, 0, 1, 5, 3);
        window(-5000, 5000);
        apply_cfg(0, 0, 1, 5, 3);
        checkpoint("s6_idle");
        apply_cfg(1, 0, 1, 5, 3);
        repeat (3) window(-5000, 5000);
        checkpoint("s6_meas");
        do_reset("s6");

        // Corrupt window reads as zero amplitude
        apply_cfg(1, 0, 0, 4, 0);
        window(100, -100);
        checkpoint("s7");

        // Random windows with occasional mode changes
        au = 1;
        apply_cfg(1, 1, 0, 4, $urandom_range(0, 2));
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 9) begin
                au = !au;
                apply_cfg(1, au, $urandom_range(0, 7), 4, $urandom_range(0, 2));
            end
            mn = int'($urandom_range(0, 2000000)) - 1000000;
            mx = mn + int'($urandom_range(0, 3000000)) - 100000;
            window(mn, mx);
        end
        checkpoint("rand");

        repeat (10) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
